// File: rtl/meas_freq_duty_if.sv
// rtl/meas_freq_duty_if.sv - control and result bundle of the frequency/duty meter
interface meas_freq_duty_if #(
    parameter int CNT_W  = 32,
    parameter int GATE_W = 32
);
    logic              start;
    logic              cont;
    logic [GATE_W-1:0] gate_len;
    logic              busy;
    logic              meas_valid;
    logic [CNT_W-1:0]  cnt_clk;
    logic [CNT_W-1:0]  cnt_squ;
    logic [CNT_W-1:0]  cnt_high;
    logic              overflow;
    logic              timeout;

    modport master (
        output start, cont, gate_len,
        input  busy, meas_valid, cnt_clk, cnt_squ, cnt_high, overflow, timeout
    );

    modport slave (
        input  start, cont, gate_len,
        output busy, meas_valid, cnt_clk, cnt_squ, cnt_high, overflow, timeout
    );
endinterface

// File: rtl/meas_freq_duty.sv
// rtl/meas_freq_duty.sv - equal-precision frequency and duty meter, rise-aligned gate
module meas_freq_duty #(
    parameter int CNT_W       = 32,
    parameter int GATE_W      = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 200_000_000
) (
    input  logic             clk_100M,
    input  logic             rst_n,
    input  logic             square,
    meas_freq_duty_if.slave  mf
);
    localparam int              TO_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ARM, OPEN, CLOSING} state_t;

    state_t            state;
    logic [SYNC_STAGES-1:0] sync;
    logic              s_d;
    logic              s;
    logic              rise;
    logic [CNT_W-1:0]  clk_cnt;
    logic [CNT_W-1:0]  squ_cnt;
    logic [CNT_W-1:0]  high_cnt;
    logic              sat_flag;
    logic [GATE_W-1:0] elapsed;
    logic [GATE_W-1:0] gate;
    logic [GATE_W-1:0] gate_eff;
    logic [TO_W-1:0]   to_cnt;
    logic              timeout_hit;
    logic              at_gate;
    logic              closing;
    logic [CNT_W-1:0]  squ_close;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && v != CNT_MAX) ? v + 1'b1 : v;
    endfunction

    assign s           = sync[SYNC_STAGES-1];
    assign rise        = s & ~s_d;
    assign gate_eff    = (mf.gate_len == '0) ? GATE_W'(1) : mf.gate_len;
    assign timeout_hit = ~rise && (to_cnt == TO_LAST);
    assign at_gate     = (elapsed == gate);
    // The closing rise also counts as a period, so the reported count is one more
    assign squ_close   = sat_inc(squ_cnt, 1'b1);
    assign closing     = rise && ((state == CLOSING) || (state == OPEN && at_gate));

    always_ff @(posedge clk_100M) begin
        if (!rst_n) begin
            sync          <= '0;
            s_d           <= 1'b0;
            state         <= IDLE;
            clk_cnt       <= '0;
            squ_cnt       <= '0;
            high_cnt      <= '0;
            sat_flag      <= 1'b0;
            elapsed       <= '0;
            gate          <= '0;
            to_cnt        <= '0;
            mf.busy       <= 1'b0;
            mf.meas_valid <= 1'b0;
            mf.cnt_clk    <= '0;
            mf.cnt_squ    <= '0;
            mf.cnt_high   <= '0;
            mf.overflow   <= 1'b0;
            mf.timeout    <= 1'b0;
        end else begin
            sync          <= {sync[SYNC_STAGES-2:0], square};
            s_d           <= s;
            mf.meas_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (mf.start || mf.cont) begin
                        state   <= ARM;
                        mf.busy <= 1'b1;
                        to_cnt  <= '0;
                    end
                end

                default: begin
                    // A window (re)opens at this rise: the rise cycle itself is t0
                    if ((state == ARM && rise) || (closing && mf.cont)) begin
                        state    <= OPEN;
                        clk_cnt  <= CNT_W'(1);
                        elapsed  <= GATE_W'(1);
                        high_cnt <= CNT_W'(1);
                        squ_cnt  <= '0;
                        sat_flag <= 1'b0;
                        gate     <= gate_eff;
                        to_cnt   <= '0;
                    end else if (closing) begin
                        state   <= IDLE;
                        mf.busy <= 1'b0;
                    end else if (timeout_hit) begin
                        to_cnt <= '0;
                        if (mf.cont) begin
                            state <= ARM;
                        end else begin
                            state   <= IDLE;
                            mf.busy <= 1'b0;
                        end
                    end else begin
                        to_cnt <= rise ? '0 : to_cnt + 1'b1;
                        if (state != ARM) begin
                            clk_cnt  <= sat_inc(clk_cnt, 1'b1);
                            high_cnt <= sat_inc(high_cnt, s);
                            squ_cnt  <= sat_inc(squ_cnt, rise);
                            elapsed  <= (elapsed != '1) ? elapsed + 1'b1 : elapsed;
                            if ((clk_cnt == CNT_MAX) || (s && high_cnt == CNT_MAX) ||
                                (rise && squ_cnt == CNT_MAX))
                                sat_flag <= 1'b1;
                            if (state == OPEN && at_gate)
                                state <= CLOSING;
                        end
                    end

                    if (closing) begin
                        mf.meas_valid <= 1'b1;
                        mf.cnt_clk    <= clk_cnt;
                        mf.cnt_squ    <= squ_close;
                        mf.cnt_high   <= high_cnt;
                        mf.overflow   <= sat_flag || (squ_cnt == CNT_MAX);
                        mf.timeout    <= 1'b0;
                    end else if (timeout_hit) begin
                        mf.meas_valid <= 1'b1;
                        mf.cnt_clk    <= '0;
                        mf.cnt_squ    <= '0;
                        mf.cnt_high   <= '0;
                        mf.overflow   <= 1'b0;
                        mf.timeout    <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule
